uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte queue directly upstream of the UART transmitter. It accepts bytes from the host at clock rate and buffers them in a FIFO.
- It launches one byte at a time into the transmitter using the transmitter's write-enable / busy handshake. Host writes never have to wait for a serial frame to finish.
- Output ports tx_din / tx_wr_en connect straight to the transmitter's data / write-enable inputs. The transmitter's busy output connects to tx_busy.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, pointer width = log2(DEPTH).
- BUSY_TMO, 4, cycles to wait for tx_busy to rise after a launch before retrying.

Ports:
- t_clk  input  1  clock; all logic on the rising edge.
- t_rst  input  1  reset; synchronous, active-high.
- din  input  8  host byte.
- wr_en  input  1  host write strobe; one byte per cycle when high.
- full  output  1  high when the FIFO holds DEPTH bytes.
- empty  output  1  high when the FIFO holds 0 bytes.
- level  output  AW+1  current occupancy, 0..DEPTH.
- tx_din  output  8  byte presented to the transmitter.
- tx_wr_en  output  1  one-cycle launch pulse to the transmitter.
- tx_busy  input  1  transmitter busy flag.
- idle  output  1  high when the FIFO is empty, the FSM is in Q_IDLE and tx_busy is low.

Behaviour:
- Reset (t_rst high at a clock edge):
  - rd_ptr = wr_ptr = 0, level = 0, empty = 1, full = 0.
  - tx_wr_en = 0, tx_din = 8'h00, FSM = Q_IDLE, timeout counter = 0.
  - Reset overrides any write or launch in the same cycle.
  - A reset in the middle of a frame drops all queued bytes. The frame already in the transmitter is not affected.
- Write:
  - If wr_en is high and full is low, din is stored at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
  - A write while full is dropped and the FIFO is unchanged.
- Pop:
  - Occurs only on the Q_IDLE -> Q_LAUNCH transition.
  - On that edge tx_din <= mem[rd_ptr] and rd_ptr increments, wrapping modulo DEPTH.
- Simultaneous write and pop in one cycle: level is unchanged and both operations take effect. This includes the case full = 1, so a write while full succeeds when a pop happens in the same cycle.
- Write into an empty FIFO: the byte becomes visible to the FSM the following cycle (no fall-through). Minimum latency from wr_en to tx_wr_en is 2 cycles.
- level, full and empty are registered and updated on the same edge as the pointers. full = (level == DEPTH); empty = (level == 0).
- FSM:
  - Q_IDLE: if empty is low and tx_busy is low, pop and go to Q_LAUNCH. Otherwise stay.
  - Q_LAUNCH: tx_wr_en = 1 for exactly this cycle; tx_din is stable. Go to Q_WAIT_ON and clear the timeout counter.
  - Q_WAIT_ON: if tx_busy is high, go to Q_WAIT_OFF. Otherwise increment the counter. When the counter reaches BUSY_TMO-1, go back to Q_LAUNCH and re-pulse the same tx_din without popping again.
  - Q_WAIT_OFF: when tx_busy is low, go to Q_IDLE.
- tx_din holds its value from pop until the next pop.
- tx_wr_en is never high in two consecutive cycles.
- Back-to-back frames: at least one Q_IDLE cycle occurs between tx_busy falling and the next tx_wr_en.

Optional Feature:
- Macro: UART_TXQ_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), reset 0.
  - ovf is set sticky when a write is attempted while full and no pop occurs in that cycle.
  - ovf is cleared only by t_rst.
- Undefined: the port is absent and dropped writes are silent.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state encoding (Q_IDLE = 2'b00, Q_LAUNCH = 2'b01, Q_WAIT_ON = 2'b10, Q_WAIT_OFF = 2'b11);
  - the byte width constant UART_BYTE_W = 8;
  - the default DEPTH.
- One sub-module, uart_sync_fifo: storage array, pointers, level, full and empty, with push/pop strobes. uart_tx_queue instantiates it and adds the FSM and timeout counter.

Test Plan:
- Reset behaviour: assert t_rst for 2 cycles while wr_en = 1, din = 8'hAA -> level = 0, empty = 1, tx_wr_en never pulses, idle = 1.
- Single byte: write 8'h5A with the transmitter model raising busy 1 cycle after tx_wr_en for 10 cycles -> tx_wr_en pulses once, 2 cycles after the write, tx_din = 8'h5A; level returns to 0; idle rises after busy falls.
- Fill and order: write 8'h01..8'h08 on consecutive cycles (DEPTH = 8) with busy held high -> full = 1 after the 8th write. A 9th write of 8'hFF is dropped (ovf = 1 if enabled). Releasing busy lets the transmitter receive 01..08 in order, never FF.
- Simultaneous events: FIFO full, pop occurs on the same edge as a write of 8'h77 -> level stays 8 and 8'h77 is transmitted last.
- Busy timeout: the transmitter model ignores the first tx_wr_en (busy stays low) -> re-pulse after BUSY_TMO cycles with the same tx_din and no extra pop; level decrements only once.
- Pointer wrap-around: stream 20 bytes 8'h10..8'h23 with random gaps -> all 20 received in order, level never exceeds 8, pointers wrap cleanly.

Source files
------------

// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: launch FSM encoding,
// byte width and default FIFO depth.
package uart_pkg;

   localparam int UART_BYTE_W        = 8;
   localparam int UART_DEPTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      Q_IDLE     = 2'b00,
      Q_LAUNCH   = 2'b01,
      Q_WAIT_ON  = 2'b10,
      Q_WAIT_OFF = 2'b11
   } q_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered level/full/empty and a combinational
// read port at rd_ptr. Pushing while full is allowed when a pop happens on the same edge.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_DEPTH_DEFAULT,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [UART_BYTE_W-1:0] din,
   output logic [UART_BYTE_W-1:0] dout,
   output logic                   full,
   output logic                   empty,
   output logic [AW:0]            level
);

   localparam logic [AW:0] LVL_ALMOST_FULL = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] LVL_ONE         = (AW+1)'(1);

   logic [UART_BYTE_W-1:0] mem [DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic                   do_push;
   logic                   do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop) begin
            level <= level + 1'b1;
            full  <= (level == LVL_ALMOST_FULL);
            empty <= 1'b0;
         end else if (do_pop && !do_push) begin
            level <= level - 1'b1;
            empty <= (level == LVL_ONE);
            full  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter via a tx_wr_en / tx_busy handshake,
// re-pulsing if busy never rises. Define UART_TXQ_OVF_EN to add the sticky 'ovf' flag.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH    = UART_DEPTH_DEFAULT,
   parameter int AW       = $clog2(DEPTH),
   parameter int BUSY_TMO = 4
) (
   input  logic                   t_clk,
   input  logic                   t_rst,
   input  logic [UART_BYTE_W-1:0] din,
   input  logic                   wr_en,
   output logic                   full,
   output logic                   empty,
   output logic [AW:0]            level,
   output logic [UART_BYTE_W-1:0] tx_din,
   output logic                   tx_wr_en,
   input  logic                   tx_busy,
`ifdef UART_TXQ_OVF_EN
   output logic                   ovf,
`endif
   output logic                   idle
);

   // BUSY_TMO must be at least 2, otherwise the retry compare can never match.
   localparam int            CW       = $clog2(BUSY_TMO) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TMO - 1);

   q_state_t               state;
   logic [CW-1:0]          cnt;
   logic                   pop;
   logic [UART_BYTE_W-1:0] fifo_dout;

   assign pop  = (state == Q_IDLE) && !empty && !tx_busy;
   assign idle = empty && (state == Q_IDLE) && !tx_busy;

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk   (t_clk),
      .rst   (t_rst),
      .push  (wr_en),
      .pop   (pop),
      .din   (din),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   // A retry re-pulses the held tx_din, so the launch period is BUSY_TMO cycles
   // while the transmitter stays silent.
   always_ff @(posedge t_clk) begin
      if (t_rst) begin
         state    <= Q_IDLE;
         tx_wr_en <= 1'b0;
         tx_din   <= '0;
         cnt      <= '0;
      end else begin
         case (state)
            Q_IDLE: begin
               if (pop) begin
                  tx_din   <= fifo_dout;
                  tx_wr_en <= 1'b1;
                  state    <= Q_LAUNCH;
               end
            end
            Q_LAUNCH: begin
               tx_wr_en <= 1'b0;
               cnt      <= '0;
               state    <= Q_WAIT_ON;
            end
            Q_WAIT_ON: begin
               if (tx_busy) begin
                  state <= Q_WAIT_OFF;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt + 1'b1 == CNT_LAST) begin
                     tx_wr_en <= 1'b1;
                     state    <= Q_LAUNCH;
                  end
               end
            end
            Q_WAIT_OFF: begin
               if (!tx_busy) state <= Q_IDLE;
            end
            default: state <= Q_IDLE;
         endcase
      end
   end

`ifdef UART_TXQ_OVF_EN
   // A full FIFO only loses the byte when no pop frees a slot on the same edge.
   always_ff @(posedge t_clk) begin
      if (t_rst) begin
         ovf <= 1'b0;
      end else if (wr_en && full && !pop) begin
         ovf <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: queue-level reference model plus a
// small transmitter model driving tx_busy; honours UART_TXQ_OVF_EN.
module tb_uart_tx_queue;

   localparam int DEPTH    = 8;
   localparam int AW       = 3;
   localparam int BUSY_TMO = 4;

   logic          t_clk = 1'b0;
   logic          t_rst;
   logic [7:0]    din;
   logic          wr_en;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic [7:0]    tx_din;
   logic          tx_wr_en;
   logic          tx_busy;
   logic          idle;
`ifdef UART_TXQ_OVF_EN
   logic          ovf;
`endif

   always #5 t_clk = ~t_clk;

   uart_tx_queue #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .BUSY_TMO (BUSY_TMO)
   ) dut (
      .t_clk    (t_clk),
      .t_rst    (t_rst),
      .din      (din),
      .wr_en    (wr_en),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .tx_din   (tx_din),
      .tx_wr_en (tx_wr_en),
      .tx_busy  (tx_busy),
`ifdef UART_TXQ_OVF_EN
      .ovf      (ovf),
`endif
      .idle     (idle)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: queued bytes, the byte held for the transmitter and when it was last pulsed.
   logic [7:0] mq[$];
   logic [7:0] m_tx_din    = 8'h00;
   bit         m_holding   = 1'b0;
   bit         m_busy_seen = 1'b0;
   bit         m_ovf       = 1'b0;
   bit         m_valid     = 1'b0;
   int         m_cyc       = 0;
   int         m_last_pulse = -100;

   // Transmitter model state and observations.
   bit         force_busy    = 1'b0;
   bit         start_pending = 1'b0;
   bit         rand_mode     = 1'b0;
   int         busy_left     = 0;
   int         frame_len     = 10;
   int         ignore_cnt    = 0;
   logic [7:0] rx[$];
   int         pulse_cyc[$];
   logic [7:0] pulse_din[$];
   int         pulse_lvl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, m_cyc);
      end
   endtask

   // Advance the model by one clock edge using the inputs applied during the cycle that just ended.
   task automatic model_edge();
      m_cyc++;
      if (t_rst) begin
         mq.delete();
         m_tx_din     = 8'h00;
         m_holding    = 1'b0;
         m_busy_seen  = 1'b0;
         m_ovf        = 1'b0;
         m_last_pulse = -100;
         m_valid      = 1'b1;
      end else if (m_valid) begin
         if (!m_holding) begin
            if (mq.size() > 0 && !tx_busy) begin
               m_tx_din     = mq.pop_front();
               m_holding    = 1'b1;
               m_busy_seen  = 1'b0;
               m_last_pulse = m_cyc;
            end
         end else if (!m_busy_seen) begin
            if ((m_cyc - 1) > m_last_pulse && tx_busy) m_busy_seen = 1'b1;
            else if ((m_cyc - m_last_pulse) == BUSY_TMO) m_last_pulse = m_cyc;
         end else if (!tx_busy) begin
            m_holding = 1'b0;
         end
         if (wr_en) begin
            if (mq.size() < DEPTH) mq.push_back(din);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic applyStimulus();
      bit ign;
      @(posedge t_clk);
      model_edge();
      #1;
      if (start_pending) begin
         busy_left     = rand_mode ? int'($urandom_range(1, 12)) : frame_len;
         start_pending = 1'b0;
      end else if (busy_left > 0) begin
         busy_left--;
      end
      tx_busy = force_busy || (busy_left > 0);
      if (tx_wr_en === 1'b1) begin
         pulse_cyc.push_back(m_cyc);
         pulse_din.push_back(tx_din);
         pulse_lvl.push_back(int'(level));
         ign = (ignore_cnt > 0) || (rand_mode && $urandom_range(0, 5) == 0);
         if (ignore_cnt > 0) ignore_cnt--;
         if (!ign) begin
            rx.push_back(tx_din);
            start_pending = 1'b1;
         end
      end
   endtask

   task automatic set_force(input bit v);
      force_busy = v;
      tx_busy    = force_busy || (busy_left > 0);
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en = 1'b1;
      din   = b;
      applyStimulus();
      wr_en = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k;
      k = 0;
      while (rx.size() < n && k < budget) begin
         applyStimulus();
         k++;
      end
      check("rx_count", rx.size(), n);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (idle !== 1'b1 && k < budget) begin
         applyStimulus();
         k++;
      end
      check("idle_reached", idle, 1);
   endtask

   task automatic clear_obs();
      rx.delete();
      pulse_cyc.delete();
      pulse_din.delete();
      pulse_lvl.delete();
   endtask

   // Every cycle after the first reset edge, the DUT outputs must equal the model.
   task automatic checkOutput();
      check("level", 32'(level), 32'(mq.size()));
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
      check("tx_wr_en", tx_wr_en, m_last_pulse == m_cyc);
      check("tx_din", tx_din, m_tx_din);
      check("idle", idle, (mq.size() == 0) && !m_holding && !tx_busy);
`ifdef UART_TXQ_OVF_EN
      check("ovf", ovf, m_ovf);
`endif
   endtask

   always @(negedge t_clk) begin
      if (m_valid) checkOutput();
   end

   initial begin
      int w;
      int gap;
      int k;

      // Reset held for two cycles while a write is attempted.
      t_rst   = 1'b1;
      wr_en   = 1'b1;
      din     = 8'hAA;
      tx_busy = 1'b0;
      applyStimulus();
      applyStimulus();
      t_rst = 1'b0;
      wr_en = 1'b0;
      check("rst_level", 32'(level), 0);
      check("rst_empty", empty, 1);
      check("rst_idle", idle, 1);
      repeat (4) applyStimulus();
      check("rst_no_pulse", pulse_cyc.size(), 0);

      // Single byte: launched two cycles after the write.
      clear_obs();
      w = m_cyc;
      write_byte(8'h5A);
      wait_rx(1, 40);
      check("single_latency", pulse_cyc[0] - w, 2);
      check("single_din", pulse_din[0], 8'h5A);
      wait_idle(40);
      check("single_pulses", pulse_cyc.size(), 1);
      check("single_level", 32'(level), 0);

      // Fill with busy held, overflow attempt, then ordered drain.
      clear_obs();
      set_force(1'b1);
      for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h01 + i));
      check("fill_full", full, 1);
      write_byte(8'hFF);
      check("fill_level", 32'(level), 8);
`ifdef UART_TXQ_OVF_EN
      check("fill_ovf", ovf, 1);
`endif
      set_force(1'b0);
      wait_rx(DEPTH, 400);
      for (int i = 0; i < DEPTH; i++) check("fill_order", rx[i], 32'(8'h01 + i));
      wait_idle(40);

      // Write on the same edge as a pop from a full FIFO.
      t_rst = 1'b1;
      applyStimulus();
      t_rst = 1'b0;
      clear_obs();
      set_force(1'b1);
      for (int i = 0; i < DEPTH; i++) write_byte(8'(8'h30 + i));
      check("simul_full", full, 1);
      set_force(1'b0);
      write_byte(8'h77);
      check("simul_level", 32'(level), 8);
      wait_rx(DEPTH + 1, 500);
      check("simul_first", rx[0], 8'h30);
      check("simul_last", rx[DEPTH], 8'h77);
      wait_idle(40);

      // Transmitter ignores the first launch pulse.
      clear_obs();
      ignore_cnt = 1;
      write_byte(8'h9C);
      write_byte(8'h9D);
      wait_rx(2, 200);
      check("tmo_pulses", pulse_cyc.size(), 3);
      check("tmo_period", pulse_cyc[1] - pulse_cyc[0], BUSY_TMO);
      check("tmo_redin", pulse_din[1], 8'h9C);
      check("tmo_lvl0", pulse_lvl[0], 1);
      check("tmo_lvl1", pulse_lvl[1], 1);
      check("tmo_rx0", rx[0], 8'h9C);
      check("tmo_rx1", rx[1], 8'h9D);
      wait_idle(40);

      // Stream of 20 bytes with random gaps; host waits while full.
      clear_obs();
      for (int i = 0; i < 20; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) applyStimulus();
         k = 0;
         while (full === 1'b1 && k < 100) begin
            applyStimulus();
            k++;
         end
         write_byte(8'(8'h10 + i));
      end
      wait_rx(20, 1000);
      for (int i = 0; i < 20; i++) check("wrap_order", rx[i], 32'(8'h10 + i));
      wait_idle(40);

      // Random traffic: heavy writes, random frame lengths, ignored pulses, rare resets.
      rand_mode = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         wr_en = ($urandom_range(0, 2) != 0);
         din   = 8'($urandom);
         t_rst = ($urandom_range(0, 299) == 0);
         applyStimulus();
      end
      t_rst     = 1'b0;
      wr_en     = 1'b0;
      rand_mode = 1'b0;
      repeat (300) applyStimulus();
      wait_idle(100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
